// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//    ALU execute stage with a valid/ready handshake on both sides. The ALU
//    result is computed when an operation is accepted and stored, together
//    with its zero and illegal flags, in a two-entry in-order buffer (head and
//    skid). The head entry drives the outputs. A saturating counter records
//    how many results have been delivered downstream.
//
// Parameters
//    WIDTH     operand and result width in bits
//    CNT_W     width of the delivered-result counter
//
// Ports
//    clk       clock, rising edge
//    reset     synchronous, active-high reset
//    in_valid  upstream operation valid
//    in_ready  stage can accept an operation this cycle
//    alu_ctrl  4-bit ALU function code
//    src_a     operand A
//    src_b     operand B
//    out_valid result/zero/illegal valid
//    out_ready downstream accepts the result
//    result    ALU result of the head entry
//    zero      head result equals 0
//    illegal   head entry had an unsupported alu_ctrl
//    op_count  number of results delivered downstream (saturating)
module alu_exec_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   occ_t             r_state;
   occ_t             w_next;

   logic [WIDTH-1:0] r_head_res;
   logic             r_head_zero;
   logic             r_head_ill;
   logic [WIDTH-1:0] r_skid_res;
   logic             r_skid_zero;
   logic             r_skid_ill;
   logic [CNT_W-1:0] r_op_count;

   logic [WIDTH-1:0] w_res;
   logic             w_ill;
   logic             w_zero;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_ld_head_new;
   logic             w_ld_head_skid;
   logic             w_ld_skid;

   // ALU function decode
   always_comb begin
      w_res = '0;
      w_ill = 1'b0;
      case (alu_ctrl)
         4'b0000: w_res = src_a & src_b;
         4'b0001: w_res = src_a | src_b;
         4'b0010: w_res = src_a + src_b;
         4'b0110: w_res = src_a - src_b;
         default: begin
            w_res = '0;
            w_ill = 1'b1;
         end
      endcase
   end

   assign w_zero = (w_res == '0);

   // in_ready depends only on registered occupancy (and reset), never on out_ready
   assign in_ready   = ~reset & (r_state != OCC_FULL);
   assign out_valid  = (r_state != OCC_EMPTY);
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   // Occupancy next-state and buffer load selects
   always_comb begin
      w_next         = r_state;
      w_ld_head_new  = 1'b0;
      w_ld_head_skid = 1'b0;
      w_ld_skid      = 1'b0;
      case (r_state)
         OCC_EMPTY: begin
            if (w_in_xfer) begin
               w_next        = OCC_ONE;
               w_ld_head_new = 1'b1;
            end
         end
         OCC_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
               w_next        = OCC_ONE;
               w_ld_head_new = 1'b1;
            end else if (w_in_xfer) begin
               w_next    = OCC_FULL;
               w_ld_skid = 1'b1;
            end else if (w_out_xfer) begin
               w_next = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            // in_ready is low here, so only the skid-to-head move can occur
            if (w_out_xfer) begin
               w_next         = OCC_ONE;
               w_ld_head_skid = 1'b1;
            end
         end
         default: w_next = OCC_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= OCC_EMPTY;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head_res  <= '0;
         r_head_zero <= 1'b0;
         r_head_ill  <= 1'b0;
         r_skid_res  <= '0;
         r_skid_zero <= 1'b0;
         r_skid_ill  <= 1'b0;
      end else begin
         if (w_ld_head_new) begin
            r_head_res  <= w_res;
            r_head_zero <= w_zero;
            r_head_ill  <= w_ill;
         end else if (w_ld_head_skid) begin
            r_head_res  <= r_skid_res;
            r_head_zero <= r_skid_zero;
            r_head_ill  <= r_skid_ill;
         end
         if (w_ld_skid) begin
            r_skid_res  <= w_res;
            r_skid_zero <= w_zero;
            r_skid_ill  <= w_ill;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_count <= '0;
      end else if (w_out_xfer && (r_op_count != '1)) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end

   assign result   = r_head_res;
   assign zero     = r_head_zero;
   assign illegal  = r_head_ill;
   assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//    Directed-vector bench for alu_exec_stage. A default-sized instance covers
//    the ALU functions, buffering, back-pressure and reset; a small instance
//    (WIDTH=8, CNT_W=2) covers result wraparound and counter saturation.
module tb_alu_exec_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic [15:0] op_count;

   logic        s_reset;
   logic        s_in_valid;
   logic        s_in_ready;
   logic [3:0]  s_alu_ctrl;
   logic [7:0]  s_src_a;
   logic [7:0]  s_src_b;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [7:0]  s_result;
   logic        s_zero;
   logic        s_illegal;
   logic [1:0]  s_op_count;

   int unsigned n_checks;
   int unsigned n_fail;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_BAD = 4'b1111;

   alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
      .op_count  (op_count)
   );

   alu_exec_stage #(.WIDTH(8), .CNT_W(2)) dut_small (
      .clk       (clk),
      .reset     (s_reset),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .alu_ctrl  (s_alu_ctrl),
      .src_a     (s_src_a),
      .src_b     (s_src_b),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .result    (s_result),
      .zero      (s_zero),
      .illegal   (s_illegal),
      .op_count  (s_op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid = v;
      alu_ctrl = op;
      src_a    = a;
      src_b    = b;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; out_ready = 1'b0;
      drive(1'b0, OP_AND, 32'h0, 32'h0);
      s_reset = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_alu_ctrl = OP_ADD; s_src_a = 8'd0; s_src_b = 8'd0;

      // reset state
      step(); step();
      check("rst_in_ready",  {31'b0, in_ready},  32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result",    result,             32'd0);
      check("rst_zero",      {31'b0, zero},      32'd0);
      check("rst_illegal",   {31'b0, illegal},   32'd0);
      check("rst_op_count",  {16'b0, op_count},  32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // ADD 5+7, one-cycle latency
      out_ready = 1'b1;
      drive(1'b1, OP_ADD, 32'd5, 32'd7);
      step();
      drive(1'b0, OP_BAD, 32'hDEAD, 32'hBEEF);
      check("add_out_valid", {31'b0, out_valid}, 32'd1);
      check("add_result",    result,             32'd12);
      check("add_zero",      {31'b0, zero},      32'd0);
      check("add_illegal",   {31'b0, illegal},   32'd0);
      check("add_cnt_before",{16'b0, op_count},  32'd0);
      step();
      check("add_cnt_after", {16'b0, op_count},  32'd1);
      check("add_drained",   {31'b0, out_valid}, 32'd0);

      // SUB equal operands then SUB underflow
      drive(1'b1, OP_SUB, 32'd9, 32'd9);
      step();
      check("sub0_result", result,        32'd0);
      check("sub0_zero",   {31'b0, zero}, 32'd1);
      drive(1'b1, OP_SUB, 32'd0, 32'd1);
      step();
      check("subm1_result", result,        32'hFFFF_FFFF);
      check("subm1_zero",   {31'b0, zero}, 32'd0);
      drive(1'b0, OP_ADD, 32'd0, 32'd0);
      step();
      check("sub_cnt", {16'b0, op_count}, 32'd3);

      // back-pressure: fill both entries, third held off
      out_ready = 1'b0;
      drive(1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
      step();
      check("bp_ready1", {31'b0, in_ready}, 32'd1);
      drive(1'b1, OP_OR, 32'h0F, 32'hF0);
      step();
      check("bp_ready2", {31'b0, in_ready}, 32'd0);
      check("bp_head",   result,            32'h0000_F000);
      drive(1'b1, OP_ADD, 32'd1, 32'd1);
      step();
      check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold_head",  result,            32'h0000_F000);
      check("bp_hold_zero",  {31'b0, zero},     32'd0);
      out_ready = 1'b1;
      step();
      check("bp_out2", result, 32'h0000_00FF);
      step();
      check("bp_out3", result, 32'd2);
      drive(1'b0, OP_ADD, 32'd0, 32'd0);
      step();
      check("bp_empty", {31'b0, out_valid}, 32'd0);
      check("bp_cnt",   {16'b0, op_count},  32'd6);

      // unsupported code and ADD wraparound
      out_ready = 1'b0;
      drive(1'b1, OP_BAD, 32'd3, 32'd4);
      step();
      check("ill_result",  result,           32'd0);
      check("ill_zero",    {31'b0, zero},    32'd1);
      check("ill_illegal", {31'b0, illegal}, 32'd1);
      out_ready = 1'b1;
      drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
      step();
      check("wrap_result",  result,           32'd0);
      check("wrap_zero",    {31'b0, zero},    32'd1);
      check("wrap_illegal", {31'b0, illegal}, 32'd0);
      drive(1'b0, OP_ADD, 32'd0, 32'd0);
      step();
      check("ill_cnt", {16'b0, op_count}, 32'd8);

      // streaming at occupancy 1 for 10 cycles, starting from a fresh counter
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b1, OP_ADD, 32'd0, 32'd100);
      step();
      for (int i = 1; i <= 10; i++) begin
         src_a = 32'(i);
         step();
         check("stream_valid", {31'b0, out_valid}, 32'd1);
         check("stream_ready", {31'b0, in_ready},  32'd1);
         check("stream_data",  result,             32'(i + 100));
      end
      check("stream_cnt", {16'b0, op_count}, 32'd10);

      // reset with two entries buffered
      out_ready = 1'b0;
      drive(1'b1, OP_OR, 32'h1, 32'h2);
      step();
      check("full_ready", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      reset = 1'b1;
      #1;
      check("rst_hi_ready", {31'b0, in_ready}, 32'd0);
      step();
      check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst2_op_count",  {16'b0, op_count},  32'd0);
      reset = 1'b0;
      drive(1'b0, OP_ADD, 32'd0, 32'd0);
      #1;
      check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      check("rst2_still_empty", {31'b0, out_valid}, 32'd0);

      // small instance: 8-bit wraparound and 2-bit counter saturation
      s_reset = 1'b0;
      s_out_ready = 1'b1;
      s_in_valid = 1'b1; s_alu_ctrl = OP_ADD; s_src_a = 8'd200; s_src_b = 8'd100;
      step();
      check("small_wrap", {24'b0, s_result}, 32'd44);
      s_src_a = 8'd1; s_src_b = 8'd1;
      for (int i = 0; i < 5; i++) step();
      check("small_sat", {30'b0, s_op_count}, 32'd3);
      s_in_valid = 1'b0;
      step();
      check("small_sat_hold", {30'b0, s_op_count}, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of the completed-operation counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset; synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream operation is valid.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the stage can accept an operation this cycle.
REQ-007 The block SHALL have port alu_ctrl, input, 4, the 4-bit ALU function code from ALU control.
REQ-008 The block SHALL have port src_a, input, WIDTH, operand A.
REQ-009 The block SHALL have port src_b, input, WIDTH, operand B.
REQ-010 The block SHALL have port out_valid, output, 1, meaning result, zero and illegal are valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the downstream stage accepts the result.
REQ-012 The block SHALL have port result, output, WIDTH, the ALU result of the head entry.
REQ-013 The block SHALL have port zero, output, 1, asserted when result equals 0; used for BEQ.
REQ-014 The block SHALL have port illegal, output, 1, asserted when the head entry had an unsupported alu_ctrl.
REQ-015 The block SHALL have port op_count, output, CNT_W, the number of results delivered downstream.

Function
REQ-016 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-017 alu_ctrl 4'b0000 SHALL produce src_a AND src_b; 4'b0001 src_a OR src_b; 4'b0010 src_a+src_b mod 2^WIDTH; 4'b0110 src_a-src_b mod 2^WIDTH, two's complement.
REQ-018 Any other alu_ctrl value SHALL store result=0 and illegal=1; supported codes SHALL store illegal=0.
REQ-019 zero SHALL be computed from the stored result and stored with it, so zero=1 for illegal entries.
REQ-020 Results SHALL be computed at input transfer and registered into a 2-entry in-order buffer: head and skid.
REQ-021 Latency SHALL be 1 cycle: with the buffer empty, an input transfer at edge N SHALL give out_valid=1 with that result after edge N.
REQ-022 in_ready SHALL be 1 exactly when fewer than 2 entries are held, decoded from registered occupancy with no combinational path from out_ready.
REQ-023 out_valid SHALL be 1 exactly when occupancy is at least 1; result, zero and illegal SHALL reflect the head entry.
REQ-024 While out_valid=1 and out_ready=0, result, zero and illegal SHALL hold stable.
REQ-025 Occupancy 0, input transfer only: occupancy SHALL become 1 and the new entry SHALL become the head.
REQ-026 Occupancy 1, input transfer only: occupancy SHALL become 2, the new entry goes to skid, and the head SHALL be unchanged.
REQ-027 Occupancy 1, simultaneous input and output transfer: occupancy SHALL stay 1 and the new entry SHALL become the head.
REQ-028 Occupancy 2, output transfer: the skid entry SHALL move to head and occupancy SHALL become 1; no input transfer is possible, since in_ready=0.
REQ-029 Occupancy 1, output transfer only: occupancy SHALL become 0.
REQ-030 Results SHALL be delivered in acceptance order with none lost or duplicated.
REQ-031 op_count SHALL increment by 1 on each output transfer and saturate at 2^CNT_W-1.
REQ-032 Input fields SHALL be ignored when no input transfer occurs.

Reset
REQ-033 With reset=1 at a rising edge, occupancy SHALL be 0; out_valid, result, zero, illegal and op_count SHALL be 0.
REQ-034 While reset=1, in_ready SHALL be 0; in the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-035 Reset SHALL take priority over a simultaneous transfer; buffered entries SHALL be discarded and op_count SHALL not increment.

Verification
REQ-036 Setup out_ready=1, then inputs ADD a=5, b=7 -> next cycle result=12, zero=0, illegal=0, out_valid=1; op_count=1 after the output transfer.
REQ-037 Inputs SUB a=9, b=9, then SUB a=0, b=1 -> first result=0 with zero=1; second result=32'hFFFFFFFF with zero=0.
REQ-038 Setup out_ready=0, then three back-to-back inputs AND(0xF0F0,0xFF00), OR(0x0F,0xF0), ADD(1,1) -> in_ready=0 after 2 accepted and the third held; release out_ready -> outputs 0xF000, 0xFF, 2 in order.
REQ-039 Input alu_ctrl=4'b1111, a=3, b=4 -> result=0, zero=1, illegal=1.
REQ-040 Setup occupancy 1 with in_valid=1 and out_ready=1 held for 10 cycles -> one result per cycle, occupancy stays 1, op_count=10.
REQ-041 Reset asserted with occupancy 2 -> out_valid=0, op_count=0 next cycle; in_ready=1 the cycle after reset deasserts.
